serial_tx: RTL and testbench

- Parallel-to-serial transmitter; the driving end of the single-bit serial lines our registered-input capture flops sample on posedge clk.
- Accepts one DATA_W-bit word per valid/ready handshake.
- Emits a frame on `out`: start bit (0), data bits LSB first, stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
- Sits between a local producer and a serial link to a remote receiver.

---
 rtl/serial_tx.sv | 116 +++++++++++
 tb/tb_serial_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_W data bits LSB first, stop bit,
// each held CLKS_PER_BIT clocks; the line output is registered and idles high.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              out,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              out_q, out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic              bit_end;

    assign tx_ready = (state_q == IDLE);
    assign accept   = tx_valid && tx_ready;
    assign bit_end  = (div_q == DIV_LAST);

    // out_d is the line value for the state being entered, so out stays aligned with state.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        out_d   = out_q;
        done_d  = 1'b0;
        if (state_q != IDLE) begin
            div_d = bit_end ? '0 : div_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                out_d = 1'b1;
                div_d = '0;
                bit_d = '0;
                if (accept) begin
                    state_d = START;
                    shift_d = tx_data;
                    out_d   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    out_d   = shift_q[0];
                end
            end
            DATA: begin
                out_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    out_d   = shift_d[0];
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        out_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                out_d = 1'b1;
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (4 and 1 clocks per bit) share stimulus and are
// compared every cycle against a frame-position model of the serial line.
module tb_serial_tx;
    localparam int DW = 8;
    localparam int CA = 4;
    localparam int CB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic a_ready, a_out, a_busy, a_done;
    logic b_ready, b_out, b_busy, b_done;

    serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CA)) u_a (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(a_ready), .out(a_out), .busy(a_busy), .done(a_done));
    serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CB)) u_b (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(b_ready), .out(b_out), .busy(b_busy), .done(b_done));

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: p = clocks since first start-bit cycle (-1 when idle), w = captured word.
    int            pa = -1, pb = -1;
    logic [DW-1:0] wa = '0, wb = '0;
    logic          da = 1'b0, db = 1'b0;
    bit            chk_en = 1'b0;
    int            cyc = 0;
    bit            mon = 1'b0;
    int            f0 = -1, dn = -1, nb = 0;

    function automatic logic exp_line(input int p, input logic [DW-1:0] w, input int cpb);
        int idx;
        if (p < 0) return 1'b1;
        idx = p / cpb;
        if (idx == 0) return 1'b0;
        if (idx == DW + 1) return 1'b1;
        return w[idx-1];
    endfunction

    task automatic model_step(inout int p, inout logic [DW-1:0] w, inout logic d, input int cpb);
        int len;
        int old;
        len = (DW + 2) * cpb;
        old = p;
        if (rst) begin
            p = -1;
            d = 1'b0;
        end else begin
            d = (old == len - 1);
            if (old >= 0) p = (old == len - 1) ? -1 : old + 1;
            else if (tx_valid) begin
                p = 0;
                w = tx_data;
            end
        end
    endtask

    task automatic tick(input logic r, input logic v, input logic [DW-1:0] d);
        @(negedge clk);
        if (chk_en) begin
            chk("a_out",   a_out,   exp_line(pa, wa, CA));
            chk("a_busy",  a_busy,  pa >= 0);
            chk("a_ready", a_ready, pa < 0);
            chk("a_done",  a_done,  da);
            chk("b_out",   b_out,   exp_line(pb, wb, CB));
            chk("b_busy",  b_busy,  pb >= 0);
            chk("b_ready", b_ready, pb < 0);
            chk("b_done",  b_done,  db);
        end
        if (mon) begin
            if (!a_out && f0 < 0) f0 = cyc;
            if (a_done && dn < 0) dn = cyc;
            if (a_busy) nb++;
        end
        rst = r;
        tx_valid = v;
        tx_data = d;
        @(posedge clk);
        model_step(pa, wa, da, CA);
        model_step(pb, wb, db, CB);
        if (r) chk_en = 1'b1;
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, DW'($urandom));
    endtask

    initial begin
        int guard;
        // reset state
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        #1;
        chk("rst_out", a_out, 1'b1);
        chk("rst_ready", a_ready, 1'b1);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_done", a_done, 1'b0);

        // basic frame with timing measurement
        mon = 1'b1;
        tick(1'b0, 1'b1, 8'hA5);
        drain(45);
        mon = 1'b0;
        chk("t1_done_dist", dn - f0, 40);
        chk("t1_busy_len", nb, 40);

        // back-to-back with valid held
        tick(1'b0, 1'b1, 8'h00);
        guard = 0;
        do begin
            tick(1'b0, 1'b1, 8'hFF);
            guard++;
        end while (!(pa == 0 && wa == 8'hFF) && guard < 100);
        if (guard >= 100) chk("t2_timeout", 0, 1);
        drain(45);

        // valid during busy
        tick(1'b0, 1'b1, 8'h5A);
        drain(10);
        tick(1'b0, 1'b1, 8'h3C);
        #1;
        chk("t3_ready_busy", a_ready, 1'b0);
        guard = 0;
        while (!(pa == 0 && wa == 8'h3C) && guard < 100) begin
            tick(1'b0, 1'b1, 8'h3C);
            guard++;
        end
        if (guard >= 100) chk("t3_timeout", 0, 1);
        drain(45);

        // data change after accept
        tick(1'b0, 1'b1, 8'hA5);
        tick(1'b0, 1'b0, 8'h00);
        drain(45);

        // reset during data bit 3
        tick(1'b0, 1'b1, 8'hC3);
        guard = 0;
        while (pa != CA * 4 + 1 && guard < 100) begin
            tick(1'b0, 1'b0, 8'hFF);
            guard++;
        end
        tick(1'b1, 1'b0, 8'h00);
        #1;
        chk("t5_out", a_out, 1'b1);
        chk("t5_busy", a_busy, 1'b0);
        chk("t5_ready", a_ready, 1'b1);
        chk("t5_done", a_done, 1'b0);
        tick(1'b0, 1'b1, 8'h96);
        drain(45);

        // one clock per bit, valid during reset ignored
        tick(1'b1, 1'b1, 8'h55);
        #1;
        chk("t6_busy_rst", b_busy, 1'b0);
        chk("t6_ready_rst", b_ready, 1'b1);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h01);
        drain(15);

        // randomized traffic
        for (int i = 0; i < 600; i++)
            tick($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, DW'($urandom));
        drain(45);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
